// File: rtl/datamem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
//   state_t    : sequencer states (IDLE, HOLD, RESP)
//   PORT_LSU   : port id of the load/store unit
//   PORT_DBG   : port id of the debug/DMA loader
//   mem_req_t  : one latched word request {we, addr, be, wdata}
package datamem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic PORT_LSU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    localparam int DEF_MEM_LAT   = 4;
    localparam int DEF_MEM_WORDS = 64;
    localparam int ADDR_W        = 15;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [3:0]        be;
        logic [31:0]       wdata;
    } mem_req_t;

endpackage

// File: rtl/datamem_arbiter_rr_arb2.sv
// Two-way round-robin grant.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : request vector, bit n = port n
//   update_en  : a grant is being taken this cycle; remember it
//   grant      : winning port id (only meaningful while |req)
// last_grant resets to the debug port so the load/store unit wins first.
module rr_arb2
    import datamem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update_en,
    output logic       grant
);

    logic last_grant_reg;

    always_comb begin
        // Contended: favour whichever port did not win last time.
        grant = (last_grant_reg == PORT_DBG) ? PORT_LSU : PORT_DBG;
        if (req == 2'b01) begin
            grant = PORT_LSU;
        end else if (req == 2'b10) begin
            grant = PORT_DBG;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= PORT_DBG;
        end else if (update_en && (|req)) begin
            last_grant_reg <= grant;
        end
    end

endmodule

// File: rtl/datamem_arbiter.sv
// Two-requester arbiter/sequencer in front of the CPU data memory.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   reqN_valid/ready/we/addr/be/wdata : word request from port N
//                                (0 = load/store unit, 1 = debug/DMA loader)
//   rspN_valid/rdata/err       : one-cycle response to port N
//   mem_wren/byteena/data/rdaddress/wraddress : memory pins
//   mem_q                      : memory read data
// One request is accepted at a time.  The memory pins are held for MEM_LAT
// cycles so the memory's half-rate read-modify-write can finish, then the
// response is pulsed on the granted port.  Out-of-range addresses skip the
// memory entirely and respond on the following cycle with err set.
module datamem_arbiter
    import datamem_arb_pkg::*;
#(
    parameter int MEM_LAT   = DEF_MEM_LAT,
    parameter int MEM_WORDS = DEF_MEM_WORDS,
    parameter int AW        = ADDR_W
)(
    input  logic          clk,
    input  logic          rst_n,

    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic          req0_we,
    input  logic [AW-1:0] req0_addr,
    input  logic [3:0]    req0_be,
    input  logic [31:0]   req0_wdata,
    output logic          rsp0_valid,
    output logic [31:0]   rsp0_rdata,
    output logic          rsp0_err,

    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic          req1_we,
    input  logic [AW-1:0] req1_addr,
    input  logic [3:0]    req1_be,
    input  logic [31:0]   req1_wdata,
    output logic          rsp1_valid,
    output logic [31:0]   rsp1_rdata,
    output logic          rsp1_err,

    output logic          mem_wren,
    output logic [3:0]    mem_byteena,
    output logic [31:0]   mem_data,
    output logic [AW-1:0] mem_rdaddress,
    output logic [AW-1:0] mem_wraddress,
    input  logic [31:0]   mem_q
);

    localparam int CW = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);
    // One extra bit so MEM_WORDS == 2**AW still compares correctly.
    localparam logic [AW:0] WORDS_LIMIT = (AW+1)'(MEM_WORDS);

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic            we_reg;
    logic            port_reg;
    logic [1:0]      rsp_valid_reg;
    logic [1:0]      rsp_err_reg;
    logic [1:0][31:0] rsp_rdata_reg;

    logic [1:0]      req_valid;
    logic [1:0]      ready;
    logic            grant;
    logic            accept;
    logic            addr_ok;
    mem_req_t        sel_req;

    assign req_valid = {req1_valid, req0_valid};
    assign accept    = (state_reg == IDLE) && (|req_valid);

    rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .update_en (accept),
        .grant     (grant)
    );

    // Ready is combinational so the requester sees it in the accept cycle.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign ready[gi] = accept && (grant == 1'(gi));
        end
    endgenerate

    assign req0_ready = ready[0];
    assign req1_ready = ready[1];

    always_comb begin
        sel_req.we    = req0_we;
        sel_req.addr  = ADDR_W'(req0_addr);
        sel_req.be    = req0_be;
        sel_req.wdata = req0_wdata;
        if (grant == PORT_DBG) begin
            sel_req.we    = req1_we;
            sel_req.addr  = ADDR_W'(req1_addr);
            sel_req.be    = req1_be;
            sel_req.wdata = req1_wdata;
        end
    end

    // Full-width compare: the memory aliases high address bits, so this is
    // the only thing stopping a wrapped write.
    assign addr_ok = ({1'b0, AW'(sel_req.addr)} < WORDS_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            we_reg        <= 1'b0;
            port_reg      <= PORT_LSU;
            rsp_valid_reg <= '0;
            rsp_err_reg   <= '0;
            rsp_rdata_reg <= '0;
            mem_wren      <= 1'b0;
            mem_byteena   <= '0;
            mem_data      <= '0;
            mem_rdaddress <= '0;
            mem_wraddress <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        we_reg   <= sel_req.we;
                        port_reg <= grant;
                        if (addr_ok) begin
                            state_reg     <= HOLD;
                            cnt_reg       <= CNT_LOAD;
                            mem_rdaddress <= AW'(sel_req.addr);
                            mem_wraddress <= AW'(sel_req.addr);
                            mem_wren      <= sel_req.we;
                            mem_byteena   <= sel_req.we ? sel_req.be : 4'h0;
                            mem_data      <= sel_req.we ? sel_req.wdata : 32'h0;
                        end else begin
                            state_reg            <= RESP;
                            rsp_valid_reg[grant] <= 1'b1;
                            rsp_err_reg[grant]   <= 1'b1;
                            rsp_rdata_reg[grant] <= 32'h0;
                        end
                    end
                end

                HOLD: begin
                    if (cnt_reg == '0) begin
                        state_reg               <= RESP;
                        mem_wren                <= 1'b0;
                        mem_byteena             <= '0;
                        mem_data                <= '0;
                        mem_rdaddress           <= '0;
                        mem_wraddress           <= '0;
                        rsp_valid_reg[port_reg] <= 1'b1;
                        rsp_err_reg[port_reg]   <= 1'b0;
                        rsp_rdata_reg[port_reg] <= we_reg ? 32'h0 : mem_q;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end

                RESP: begin
                    state_reg     <= IDLE;
                    rsp_valid_reg <= '0;
                    rsp_err_reg   <= '0;
                    rsp_rdata_reg <= '0;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign rsp0_valid = rsp_valid_reg[0];
    assign rsp0_err   = rsp_err_reg[0];
    assign rsp0_rdata = rsp_rdata_reg[0];
    assign rsp1_valid = rsp_valid_reg[1];
    assign rsp1_err   = rsp_err_reg[1];
    assign rsp1_rdata = rsp_rdata_reg[1];

endmodule

// File: tb/tb_datamem_arbiter.sv
// Testbench for datamem_arbiter: table-driven single-port requests against a
// behavioural byte-lane memory, plus hand-written sequences for contention,
// and reset during a write.
module tb_datamem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req0_we = 1'b0;
    logic [14:0] req0_addr = '0;
    logic [3:0]  req0_be = '0;
    logic [31:0] req0_wdata = '0;
    logic        req1_valid = 1'b0, req1_we = 1'b0;
    logic [14:0] req1_addr = '0;
    logic [3:0]  req1_be = '0;
    logic [31:0] req1_wdata = '0;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic        mem_wren;
    logic [3:0]  mem_byteena;
    logic [31:0] mem_data;
    logic [14:0] mem_rdaddress, mem_wraddress;
    logic [31:0] mem_q = '0;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    datamem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_be(req0_be), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_be(req1_be), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .mem_wren(mem_wren), .mem_byteena(mem_byteena), .mem_data(mem_data),
        .mem_rdaddress(mem_rdaddress), .mem_wraddress(mem_wraddress), .mem_q(mem_q)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural memory: 64 words, high address bits alias, registered q.
    logic [31:0] mem_arr [64];

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_wren) mem_arr[mem_wraddress[5:0]] <= merge(mem_arr[mem_wraddress[5:0]], mem_data, mem_byteena);
        mem_q <= mem_arr[mem_rdaddress[5:0]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          port;
        bit          we;
        logic [14:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          lat;
        bit          err;
        logic [31:0] rdata;
        int          wren;
    } vec_t;

    task automatic do_req(input vec_t v, output int lat, output logic [31:0] rdata,
                          output bit err, output int wren_cnt, output bit other_rsp,
                          output bit timed_out);
        int t0;
        bit got, done;
        lat = -1; rdata = '0; err = 0; wren_cnt = 0; other_rsp = 0; timed_out = 0;
        got = 0; done = 0; t0 = 0;
        if (!v.port) begin
            req0_valid = 1; req0_we = v.we; req0_addr = v.addr; req0_be = v.be; req0_wdata = v.wdata;
        end else begin
            req1_valid = 1; req1_we = v.we; req1_addr = v.addr; req1_be = v.be; req1_wdata = v.wdata;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if ((v.port ? req1_ready : req0_ready) === 1'b1) begin
                got = 1;
                t0 = cyc;
            end
        end
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        if (!got) begin
            timed_out = 1;
            return;
        end
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (mem_wren === 1'b1) wren_cnt++;
            if ((v.port ? rsp0_valid : rsp1_valid) === 1'b1) other_rsp = 1;
            if ((v.port ? rsp1_valid : rsp0_valid) === 1'b1) begin
                done  = 1;
                lat   = cyc - t0;
                rdata = v.port ? rsp1_rdata : rsp0_rdata;
                err   = v.port ? rsp1_err : rsp0_err;
            end
        end
        if (!done) timed_out = 1;
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    vec_t vecs[16];

    initial begin
        int          lat, wren_cnt;
        logic [31:0] rdata;
        bit          err, other, tmo;
        int          g_port[$];
        int          g_cyc[$];
        int          n_rsp0, n_rsp1, last_port;
        bit          both_ready, got;

        for (int i = 0; i < 64; i++) mem_arr[i] = 32'h0;

        //            port we  addr       be     wdata          lat err rdata          wren
        vecs[0]  = '{1'b0, 1'b1, 15'd5,     4'hF, 32'hDEADBEEF, 5, 1'b0, 32'h0,        4};
        vecs[1]  = '{1'b0, 1'b0, 15'd5,     4'h0, 32'h0,        5, 1'b0, 32'hDEADBEEF, 0};
        vecs[2]  = '{1'b0, 1'b1, 15'd7,     4'hF, 32'h11223344, 5, 1'b0, 32'h0,        4};
        vecs[3]  = '{1'b1, 1'b1, 15'd7,     4'h4, 32'h00AA0000, 5, 1'b0, 32'h0,        4};
        vecs[4]  = '{1'b0, 1'b0, 15'd7,     4'h0, 32'h0,        5, 1'b0, 32'h11AA3344, 0};
        vecs[5]  = '{1'b0, 1'b1, 15'd0,     4'hF, 32'h0BADC0DE, 5, 1'b0, 32'h0,        4};
        vecs[6]  = '{1'b1, 1'b1, 15'd64,    4'hF, 32'hFFFFFFFF, 1, 1'b1, 32'h0,        0};
        vecs[7]  = '{1'b1, 1'b0, 15'd0,     4'h0, 32'h0,        5, 1'b0, 32'h0BADC0DE, 0};
        vecs[8]  = '{1'b0, 1'b1, 15'd3,     4'hF, 32'hCAFEF00D, 5, 1'b0, 32'h0,        4};
        vecs[9]  = '{1'b1, 1'b1, 15'd3,     4'h0, 32'h12345678, 5, 1'b0, 32'h0,        4};
        vecs[10] = '{1'b0, 1'b0, 15'd3,     4'h0, 32'h0,        5, 1'b0, 32'hCAFEF00D, 0};
        vecs[11] = '{1'b1, 1'b0, 15'h7FFF,  4'h0, 32'h0,        1, 1'b1, 32'h0,        0};
        vecs[12] = '{1'b0, 1'b0, 15'd63,    4'h0, 32'h0,        5, 1'b0, 32'h0,        0};
        vecs[13] = '{1'b1, 1'b1, 15'd1,     4'hF, 32'h00000101, 5, 1'b0, 32'h0,        4};
        vecs[14] = '{1'b0, 1'b1, 15'd2,     4'hF, 32'h00000202, 5, 1'b0, 32'h0,        4};
        vecs[15] = '{1'b1, 1'b1, 15'd65,    4'hF, 32'h0,        1, 1'b1, 32'h0,        0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst req0_ready", 32'(req0_ready), 32'h0);
        check("rst rsp0_valid", 32'(rsp0_valid), 32'h0);
        check("rst rsp1_valid", 32'(rsp1_valid), 32'h0);
        check("rst mem_wren", 32'(mem_wren), 32'h0);
        check("rst mem_byteena", 32'(mem_byteena), 32'h0);
        check("rst mem_data", mem_data, 32'h0);
        check("rst mem_rdaddress", 32'(mem_rdaddress), 32'h0);
        check("rst mem_wraddress", 32'(mem_wraddress), 32'h0);
        rst_n = 1;
        @(posedge clk); #1;

        // Table-driven single-port transactions
        for (int k = 0; k < 16; k++) begin
            do_req(vecs[k], lat, rdata, err, wren_cnt, other, tmo);
            $display("vec %0d: port %0d we %0d addr %0d -> lat %0d err %0d rdata %h wren_cycles %0d",
                     k, vecs[k].port, vecs[k].we, vecs[k].addr, lat, err, rdata, wren_cnt);
            check($sformatf("vec%0d timeout", k), 32'(tmo), 32'h0);
            check($sformatf("vec%0d latency", k), 32'(lat), 32'(vecs[k].lat));
            check($sformatf("vec%0d err", k), 32'(err), 32'(vecs[k].err));
            check($sformatf("vec%0d rdata", k), rdata, vecs[k].rdata);
            check($sformatf("vec%0d wren_cycles", k), 32'(wren_cnt), 32'(vecs[k].wren));
            check($sformatf("vec%0d other_port_rsp", k), 32'(other), 32'h0);
        end
        check("alias addr0 untouched", mem_arr[0], 32'h0BADC0DE);
        check("alias addr1 untouched", mem_arr[1], 32'h00000101);

        // Contention: both ports valid every cycle after a fresh reset
        apply_reset();
        req0_valid = 1; req0_we = 0; req0_addr = 15'd1; req0_be = 0; req0_wdata = 0;
        req1_valid = 1; req1_we = 0; req1_addr = 15'd2; req1_be = 0; req1_wdata = 0;
        n_rsp0 = 0; n_rsp1 = 0; last_port = -1; both_ready = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (req0_ready && req1_ready) both_ready = 1;
            if (req0_ready) begin g_port.push_back(0); g_cyc.push_back(cyc); last_port = 0; end
            if (req1_ready) begin g_port.push_back(1); g_cyc.push_back(cyc); last_port = 1; end
            if (rsp0_valid) begin
                n_rsp0++;
                check("rr rsp0 owner", 32'(last_port), 32'h0);
                check("rr rsp0 rdata", rsp0_rdata, 32'h00000101);
            end
            if (rsp1_valid) begin
                n_rsp1++;
                check("rr rsp1 owner", 32'(last_port), 32'h1);
                check("rr rsp1 rdata", rsp1_rdata, 32'h00000202);
            end
        end
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        $display("contention: %0d grants, %0d rsp0, %0d rsp1", g_port.size(), n_rsp0, n_rsp1);
        check("rr both ready", 32'(both_ready), 32'h0);
        check("rr grant count", 32'(g_port.size()), 32'd4);
        if (g_port.size() == 4) begin
            for (int j = 0; j < 4; j++) begin
                check($sformatf("rr grant%0d port", j), 32'(g_port[j]), 32'(j % 2));
                if (j > 0) check($sformatf("rr spacing%0d", j), 32'(g_cyc[j] - g_cyc[j-1]), 32'd6);
            end
        end
        check("rr rsp0 count", 32'(n_rsp0), 32'd2);
        check("rr rsp1 count", 32'(n_rsp1), 32'd2);
        @(posedge clk); #1;

        // Reset two cycles into a HOLD write
        req0_valid = 1; req0_we = 1; req0_addr = 15'd9; req0_be = 4'hF; req0_wdata = 32'h55555555;
        @(negedge clk);
        check("rsthold ready0", 32'(req0_ready), 32'h1);
        @(posedge clk); #1;
        req0_valid = 0;
        @(negedge clk);
        @(negedge clk);
        check("rsthold wren before reset", 32'(mem_wren), 32'h1);
        #1 rst_n = 0;
        #1;
        check("rsthold wren async drop", 32'(mem_wren), 32'h0);
        check("rsthold byteena", 32'(mem_byteena), 32'h0);
        got = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid) got = 1;
        end
        rst_n = 1;
        repeat (3) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid) got = 1;
        end
        check("rsthold no rsp", 32'(got), 32'h0);
        @(posedge clk); #1;
        req0_valid = 1; req0_we = 0; req0_addr = 15'd1;
        req1_valid = 1; req1_we = 0; req1_addr = 15'd2;
        @(negedge clk);
        $display("post-reset both valid: ready0 %0d ready1 %0d", req0_ready, req1_ready);
        check("post-reset ready0", 32'(req0_ready), 32'h1);
        check("post-reset ready1", 32'(req1_ready), 32'h0);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (rsp0_valid) begin
                got = 1;
                check("post-reset rsp0 rdata", rsp0_rdata, 32'h00000101);
            end
        end
        check("post-reset rsp0 seen", 32'(got), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/datamem_arbiter.md
Name: datamem_arbiter

Overview:
Two-requester arbiter and sequencer in front of the CPU data memory. Port 0 is the load/store unit and port 1 is the debug/DMA loader. The block accepts one word request at a time under round-robin arbitration and drives the memory's read/write address, data, byte-enable and wren pins. It holds those pins stable long enough for the memory's internal half-rate read-modify-write to complete, then returns a one-cycle response to the granted requester.

Parameters:
MEM_LAT, 4, clk cycles the memory pins are held per access; must be even and >= 4 (two slow-clock edges: RMW capture, then write).
MEM_WORDS, 64, implemented words; word addresses >= MEM_WORDS are rejected.
AW, 15, word-address width of request and memory ports.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  port 0 request
req0_ready  out  1  port 0 accepted this cycle
req0_we  in  1  1 = write, 0 = read
req0_addr  in  AW  word address
req0_be  in  4  byte enables (writes only)
req0_wdata  in  32  write data
rsp0_valid  out  1  port 0 response pulse
rsp0_rdata  out  32  read data (0 on writes and errors)
rsp0_err  out  1  address out of range
req1_* / rsp1_*  same as port 0, for port 1
mem_wren  out  1  to memory wren
mem_byteena  out  4  to memory byteena_a
mem_data  out  32  to memory data
mem_rdaddress  out  AW  to memory rdaddress
mem_wraddress  out  AW  to memory wraddress
mem_q  in  32  from memory q

Behaviour:
- Reset (async, rst_n=0): state IDLE; all ready/rsp outputs 0; mem_wren=0, mem_byteena=0, mem_data=0, both mem addresses 0; hold counter 0; last_grant=1, so port 0 wins first.
- FSM states: IDLE, HOLD, RESP.
- IDLE: if any reqN_valid, grant per round-robin and pulse reqN_ready for exactly that cycle.
  - Both valid: grant the port that is not last_grant.
  - One valid: grant it regardless of last_grant.
  - Latch we, addr, be, wdata, port id; update last_grant.
  - Go to HOLD if addr < MEM_WORDS, else RESP with err flag set.
- HOLD: memory pins are driven from the latched request for exactly MEM_LAT cycles (counter MEM_LAT-1 down to 0).
  - mem_rdaddress = mem_wraddress = latched addr; mem_wren = latched we; mem_byteena = latched be on writes, 0 on reads; mem_data = latched wdata on writes, 0 on reads.
  - When the counter reaches 0, capture mem_q into the rdata register (reads only) and go to RESP.
- RESP: pulse rspN_valid for 1 cycle on the granted port only; rspN_rdata = captured data (0 on writes and errors); rspN_err = error flag. All mem pins return to 0 with mem_wren=0. Next state IDLE.
- Latency:
  - Accept cycle t; memory pins active t+1..t+MEM_LAT; response at t+MEM_LAT+1.
  - Error requests respond at t+1 and never touch memory; mem_wren stays 0.
  - Minimum accept-to-accept spacing is MEM_LAT+2 cycles.
- Requests are ignored outside IDLE. The requester must hold valid and payload stable until it sees ready; after ready it may change them.
- be=0 write: performs a full memory cycle; memory content is unchanged; responds normally.
- A read following a write to the same address returns the new data, since accesses are fully serialised.
- Reset mid-HOLD: mem_wren drops asynchronously, no response is issued, and the partial write is undefined in memory.
- Width rule: out-of-range check is a full AW-bit unsigned compare against MEM_WORDS. The memory itself aliases high address bits, so this check is the only protection.

Decomposition:
- Package datamem_arb_pkg:
  - state enum {IDLE, HOLD, RESP};
  - PORT_LSU=0 and PORT_DBG=1 constants;
  - default MEM_LAT and MEM_WORDS localparams;
  - request struct {we, addr, be, wdata}.
- Sub-module rr_arb2: 2-way round-robin grant with a last_grant register, same clk/rst_n, and an update-enable input.

Test Plan:
- Port 0 write addr 5, be=4'hF, wdata=32'hDEADBEEF; then port 0 read addr 5 -> write response at t+5 with err=0; read returns rdata=32'hDEADBEEF; mem_wren high exactly 4 cycles, only during the write.
- Byte-lane RMW: write 32'h11223344 to addr 7, then write be=4'b0100 wdata=32'h00AA0000 -> readback of addr 7 = 32'h11AA3344.
- Both ports valid every cycle, port 0 reading addr 1 and port 1 reading addr 2 -> grants alternate 0,1,0,1; each response appears only on its own port; accept spacing is exactly 6 cycles.
- Out-of-range: port 1 write addr 64 -> ready at t, rsp1_valid with err=1 and rdata=0 at t+1; mem_wren never asserted; addr 0 still holds its prior value.
- Reset asserted 2 cycles into a HOLD write -> mem_wren=0 in the same cycle; no rsp pulse; after release the first request with both ports valid grants port 0.
- be=4'b0000 write to addr 3 holding 32'hCAFEF00D -> normal response; readback = 32'hCAFEF00D.
